// File: rtl/if_id_buffer_pkg.sv
// ---------------------------------------------------------------------------
// if_id_buffer_pkg
//   Shared definitions for the fetch/decode decoupling buffer: entry field
//   widths, the default depth, the NOP word presented to decode when the
//   buffer is empty, the stored entry layout and a saturating adder used by
//   the optional performance counters.
// ---------------------------------------------------------------------------
package if_id_buffer_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int CNT_W   = 16;

  localparam int DEFAULT_DEPTH = 2;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_WORD = 16'h0800;

  // One buffered fetch result. The err flag travels with its own word and
  // is never combined with neighbouring entries.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc2;
    logic               err;
  } entry_t;

  // Adds inc to base and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_buffer_if
//   Bundles the fetch-side and decode-side signals of the IF/ID buffer.
//   master : the pipeline around the buffer (fetch + decode + redirect)
//   slave  : the buffer itself
//   Fetch side : Instruction, PC_plus_two, IC_Stall, fetch_err -> buffer
//                fetch_stall <- buffer
//   Decode side: dec_stall, flush -> buffer
//                Instruction_D, PC_plus_two_D, valid_D, err_D, occupancy
//                <- buffer
// ---------------------------------------------------------------------------
interface if_id_buffer_if
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);

  logic [INSTR_W-1:0]      Instruction;
  logic [PC_W-1:0]         PC_plus_two;
  logic                    IC_Stall;
  logic                    fetch_err;
  logic                    dec_stall;
  logic                    flush;
  logic                    fetch_stall;
  logic [INSTR_W-1:0]      Instruction_D;
  logic [PC_W-1:0]         PC_plus_two_D;
  logic                    valid_D;
  logic                    err_D;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output Instruction, PC_plus_two, IC_Stall, fetch_err, dec_stall, flush,
    input  fetch_stall, Instruction_D, PC_plus_two_D, valid_D, err_D, occupancy
  );

  modport slave (
    input  Instruction, PC_plus_two, IC_Stall, fetch_err, dec_stall, flush,
    output fetch_stall, Instruction_D, PC_plus_two_D, valid_D, err_D, occupancy
  );

endinterface

// File: rtl/if_id_buffer_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Pointer and occupancy bookkeeping for the IF/ID buffer. Decides whether
//   an enqueue and/or dequeue happens this cycle, and clears everything on
//   flush (flush outranks both transfers; rst outranks flush).
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     wr_req     : fetch offers a word (IC_Stall low)
//     rd_req     : decode can consume (dec_stall low)
//     flush      : redirect, squash all entries
//     enq, deq   : the transfers actually performed this cycle
//     full/empty : occupancy decodes
//     wr_ptr     : slot written on enq
//     rd_ptr     : head slot
//     occupancy  : number of stored entries (0..DEPTH)
//   DEPTH must be a power of two, at least 2, so the pointers wrap on their
//   natural overflow.
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             flush,
  output logic             enq,
  output logic             deq,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0] occupancy
);

  // full is decoded from registered occupancy only, so fetch_stall never
  // depends on dec_stall; a word offered while full is refused even if the
  // head leaves in the same cycle, and fetch simply retries.
  always_comb begin
    full  = (occupancy == OCC_W'(DEPTH));
    empty = (occupancy == '0);
    enq   = wr_req & ~full & ~flush;
    deq   = rd_req & ~empty & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Decoupling FIFO between fetch and decode. Each word fetch completes
//   (IC_Stall low) is stored together with its PC+2 and error flag and is
//   presented to decode one cycle later, in order. The buffer raises
//   fetch_stall while full and drops all wrong-path entries on flush.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : if_id_buffer_if.slave (fetch inputs, decode outputs,
//                fetch_stall, occupancy)
//   Optional feature (macro IF_ID_PERF_CNT_EN):
//     stall_cycles : saturating count of cycles with fetch_stall high
//     flush_drops  : saturating count of valid entries discarded by flush
// ---------------------------------------------------------------------------
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int                 DEPTH    = DEFAULT_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  if_id_buffer_if.slave      bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_drops
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic             enq;
  logic             deq;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;

  entry_t mem [DEPTH];
  entry_t head;

  fifo_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (~bus.IC_Stall),
    .rd_req   (~bus.dec_stall),
    .flush    (bus.flush),
    .enq      (enq),
    .deq      (deq),
    .full     (full),
    .empty    (empty),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .occupancy(occupancy)
  );

  // Entry storage needs no reset: nothing reads a slot until it has been
  // written, because the output mux masks the head whenever empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{instr: bus.Instruction,
                       pc2:   bus.PC_plus_two,
                       err:   bus.fetch_err};
    end
  end

  assign head = mem[rd_ptr];

  // Head presentation. An empty buffer shows a NOP with zero PC and no
  // error so decode sees a harmless bubble.
  always_comb begin
    bus.valid_D       = ~empty;
    bus.Instruction_D = NOP_WORD;
    bus.PC_plus_two_D = '0;
    bus.err_D         = 1'b0;
    if (!empty) begin
      bus.Instruction_D = head.instr;
      bus.PC_plus_two_D = head.pc2;
      bus.err_D         = head.err;
    end
  end

  assign bus.fetch_stall = full;
  assign bus.occupancy   = occupancy;

`ifdef IF_ID_PERF_CNT_EN
  // flush_drops adds the entries held at the moment of the flush, which is
  // exactly the registered occupancy on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (full) begin
        stall_cycles <= sat_add(stall_cycles, CNT_W'(1));
      end
      if (bus.flush) begin
        flush_drops <= sat_add(flush_drops, CNT_W'(occupancy));
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//   Self-checking bench for if_id_buffer. Words accepted by fetch are pushed
//   to a scoreboard queue and popped as decode consumes them; the queue head
//   gives the expected decode-side view each cycle.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int OBS_W = 1 + INSTR_W + PC_W + 1 + OCC_W + 1;

  logic clk;
  logic rst;

  if_id_buffer_if #(.DEPTH(DEPTH)) bus ();

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_drops;
  int exp_stall;
  int exp_drops;
`endif

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_drops(flush_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t sb[$];
  int vectors;
  int miscompares;

  // Drives one cycle of stimulus, waits for the edge, updates the scoreboard
  // with what the buffer is supposed to have done, then steps clear of the
  // edge so outputs can be sampled.
  task automatic drive(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ics, input logic ferr, input logic dst, input logic fl);
    bit full_pre;
    entry_t e;
    rst             = r;
    bus.Instruction = ins;
    bus.PC_plus_two = pc;
    bus.IC_Stall    = ics;
    bus.fetch_err   = ferr;
    bus.dec_stall   = dst;
    bus.flush       = fl;
    @(posedge clk);
    full_pre = (sb.size() == DEPTH);
    if (r) begin
      sb.delete();
`ifdef IF_ID_PERF_CNT_EN
      exp_stall = 0;
      exp_drops = 0;
`endif
    end else begin
`ifdef IF_ID_PERF_CNT_EN
      if (full_pre) exp_stall++;
      if (fl) exp_drops += sb.size();
`endif
      if (fl) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && !dst) void'(sb.pop_front());
        if (!ics && !full_pre) begin
          e.instr = ins;
          e.pc2   = pc;
          e.err   = ferr;
          sb.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected decode-side view: {valid, instr, pc2, err, occupancy, fetch_stall}.
  function automatic logic [OBS_W-1:0] model_obs();
    logic [INSTR_W-1:0] i;
    logic [PC_W-1:0]    p;
    logic               er;
    i  = 16'h0800;
    p  = '0;
    er = 1'b0;
    if (sb.size() != 0) begin
      i  = sb[0].instr;
      p  = sb[0].pc2;
      er = sb[0].err;
    end
    return {sb.size() != 0, i, p, er, OCC_W'(sb.size()), sb.size() == DEPTH};
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall} !== {1'b1 ^ 1'b1, 16'h0800, OCC_W'(0), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_state cyc%0d: got v=%b i=%h o=%0d s=%b, want v=0 i=0800 o=0 s=0",
                 k, bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall);
      end
    end
    idle();
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D} !== {1'b0, 16'h0800, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got v=%b i=%h p=%h e=%b, want v=0 i=0800 p=0000 e=0",
               bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] words [3];
    words[0] = 16'hA001;
    words[1] = 16'hA002;
    words[2] = 16'hA003;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, words[k], 16'h0102 + 16'(2 * k), 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.Instruction_D !== words[k] || bus.occupancy > OCC_W'(1) || bus.valid_D !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stream_word%0d: got i=%h o=%0d v=%b, want i=%h o<=1 v=1",
                 k, bus.Instruction_D, bus.occupancy, bus.valid_D, words[k]);
      end
      vectors++;
      if ({bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall} !== model_obs()) begin
        miscompares++;
        $display("[TB] FAIL stream_obs%0d: got %h want %h", k,
                 {bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall}, model_obs());
      end
    end
    idle();
    vectors++;
    if (bus.valid_D !== 1'b0 || bus.occupancy !== OCC_W'(0)) begin
      miscompares++;
      $display("[TB] FAIL stream_drain: got v=%b o=%0d, want v=0 o=0", bus.valid_D, bus.occupancy);
    end
  endtask

  task automatic test_fill_backpressure();
    logic [15:0] heads [3];
    drive(1'b0, 16'hB001, 16'h0202, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'hB002, 16'h0204, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'hB003, 16'h0206, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (bus.occupancy !== OCC_W'(2) || bus.fetch_stall !== 1'b1 || bus.Instruction_D !== 16'hB001) begin
      miscompares++;
      $display("[TB] FAIL fill_full: got o=%0d s=%b i=%h, want o=2 s=1 i=B001",
               bus.occupancy, bus.fetch_stall, bus.Instruction_D);
    end
    // Release decode while fetch keeps offering B003: the first edge still
    // refuses it, the second accepts it.
    heads[0] = 16'hB002;
    heads[1] = 16'hB003;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 16'hB003, 16'h0206, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.Instruction_D !== heads[k] || bus.fetch_stall !== 1'b0 || bus.occupancy !== OCC_W'(1)) begin
        miscompares++;
        $display("[TB] FAIL fill_drain%0d: got i=%h s=%b o=%0d, want i=%h s=0 o=1",
                 k, bus.Instruction_D, bus.fetch_stall, bus.occupancy, heads[k]);
      end
    end
    idle();
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall} !== model_obs()) begin
      miscompares++;
      $display("[TB] FAIL fill_end: got %h want %h",
               {bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall}, model_obs());
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 16'hE001, 16'h0302, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'hE002, 16'h0304, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'hE003, 16'h0306, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall} !== {1'b0, 16'h0800, OCC_W'(0), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got v=%b i=%h o=%0d s=%b, want v=0 i=0800 o=0 s=0",
               bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall);
    end
    drive(1'b0, 16'hC000, 16'h0402, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.occupancy} !== {1'b1, 16'hC000, 16'h0402, OCC_W'(1)}) begin
      miscompares++;
      $display("[TB] FAIL flush_after: got v=%b i=%h p=%h o=%0d, want v=1 i=C000 p=0402 o=1",
               bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.occupancy);
    end
    drive(1'b0, 16'hC001, 16'h0404, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'hC002, 16'h0406, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.occupancy} !== {1'b0, 16'h0800, OCC_W'(0)}) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: got v=%b i=%h o=%0d, want v=0 i=0800 o=0",
               bus.valid_D, bus.Instruction_D, bus.occupancy);
    end
  endtask

  task automatic test_ic_stall_gaps();
    logic [15:0] want_i [5];
    logic        want_e [5];
    logic        ics    [5];
    logic        ferr   [5];
    logic [15:0] ins    [5];
    ins[0] = 16'hDEAD; ics[0] = 1'b1; ferr[0] = 1'b1; want_i[0] = 16'h0800; want_e[0] = 1'b0;
    ins[1] = 16'hD001; ics[1] = 1'b0; ferr[1] = 1'b0; want_i[1] = 16'hD001; want_e[1] = 1'b0;
    ins[2] = 16'hDEAD; ics[2] = 1'b1; ferr[2] = 1'b1; want_i[2] = 16'h0800; want_e[2] = 1'b0;
    ins[3] = 16'hD002; ics[3] = 1'b0; ferr[3] = 1'b1; want_i[3] = 16'hD002; want_e[3] = 1'b1;
    ins[4] = 16'hDEAD; ics[4] = 1'b1; ferr[4] = 1'b1; want_i[4] = 16'h0800; want_e[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, ins[k], 16'h0500, ics[k], ferr[k], 1'b0, 1'b0);
      vectors++;
      if (bus.Instruction_D !== want_i[k] || bus.err_D !== want_e[k]) begin
        miscompares++;
        $display("[TB] FAIL gaps_step%0d: got i=%h e=%b, want i=%h e=%b",
                 k, bus.Instruction_D, bus.err_D, want_i[k], want_e[k]);
      end
    end
  endtask

  task automatic test_dec_stall_empty();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({bus.valid_D, bus.occupancy, bus.fetch_stall} !== {1'b0, OCC_W'(0), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL dstall_empty: got v=%b o=%0d s=%b, want v=0 o=0 s=0",
               bus.valid_D, bus.occupancy, bus.fetch_stall);
    end
    drive(1'b0, 16'h7001, 16'h0602, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.err_D} !== {1'b1, 16'h7001, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL dstall_capture: got v=%b i=%h e=%b, want v=1 i=7001 e=1",
               bus.valid_D, bus.Instruction_D, bus.err_D);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 16'h8002, 16'h0702, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'h8003, 16'h0704, 1'b0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall} !== {1'b0, 16'h0800, OCC_W'(0), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got v=%b i=%h o=%0d s=%b, want v=0 i=0800 o=0 s=0",
               bus.valid_D, bus.Instruction_D, bus.occupancy, bus.fetch_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int k = 0; k < 400; k++) begin
      ins = 16'($urandom);
      drive(($urandom_range(0, 99) == 0), ins, ins + 16'd2,
            ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
      vectors++;
      if ({bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall} !== model_obs()) begin
        miscompares++;
        $display("[TB] FAIL random_cyc%0d: got %h want %h", k,
                 {bus.valid_D, bus.Instruction_D, bus.PC_plus_two_D, bus.err_D, bus.occupancy, bus.fetch_stall}, model_obs());
      end
    end
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_perf_counters();
    drive(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h9001, 16'h0802, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h9002, 16'h0804, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 16'h9003, 16'h0806, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (stall_cycles !== 16'd5 || flush_drops !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_stall: got stall=%0d drops=%0d, want stall=5 drops=0", stall_cycles, flush_drops);
    end
    drive(1'b0, 16'h9003, 16'h0806, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (flush_drops !== 16'd2 || stall_cycles !== 16'(exp_stall)) begin
      miscompares++;
      $display("[TB] FAIL perf_flush: got drops=%0d stall=%0d, want drops=2 stall=%0d",
               flush_drops, stall_cycles, exp_stall);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef IF_ID_PERF_CNT_EN
    exp_stall = 0;
    exp_drops = 0;
`endif
    rst             = 1'b1;
    bus.Instruction = '0;
    bus.PC_plus_two = '0;
    bus.IC_Stall    = 1'b1;
    bus.fetch_err   = 1'b0;
    bus.dec_stall   = 1'b0;
    bus.flush       = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_fill_backpressure();
    test_flush();
    test_ic_stall_gaps();
    test_dec_stall_empty();
    test_reset_mid();
    test_back_to_back();
`ifdef IF_ID_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
